duty_ramp_ctrl: RTL and testbench
=================================

Name: duty_ramp_ctrl

Overview:
- Upstream stage of the PWM duty generator.
- Synchronises and debounces the 8-bit slide-switch bank into a target duty value.
- Slews the delivered DUTY toward that target by a fixed step once per PWM frame, so the PWM output never jumps abruptly.
- DUTY drives the PWM generator's duty compare input directly.

Parameters:
- WIDTH, 8: width of SW, target and DUTY.
- SYNC_STAGES, 2: flop stages in the SW synchroniser, minimum 2.
- DEBOUNCE_CYCLES, 100000: consecutive stable synchronised cycles required before a new target is accepted, minimum 1.
- STEP_CYCLES, 257: clocks between ramp steps. The default equals one downstream PWM frame.
- STEP, 1: DUTY increment/decrement per step, 1..2^WIDTH-1.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- SW  in  WIDTH  raw asynchronous switch bank, requested duty.
- HOLD  in  1  synchronous; 1 freezes DUTY (ticks ignored). Debounce and timer keep running.
- DUTY  out  WIDTH  registered duty value to the PWM generator.
- AT_TARGET  out  1  registered; 1 when DUTY equals the accepted target.
- UPDATE  out  1  registered one-cycle pulse, high the cycle after DUTY changes.

Behaviour:
- Reset (RST_N=0, asynchronous) forces:
  - synchroniser flops, candidate, target, DUTY: 0;
  - debounce counter and step timer: 0;
  - FSM: IDLE;
  - AT_TARGET=1, UPDATE=0.
- Release is synchronous to CLK. Reset mid-ramp discards target and ramp; DUTY returns to 0 immediately.
- Synchroniser: SW passes through SYNC_STAGES flops to give sync_sw. No combinational path from SW.
- Debounce, evaluated each edge:
  - If sync_sw != candidate: candidate<=sync_sw, cnt<=0.
  - Else if cnt < DEBOUNCE_CYCLES-1: cnt<=cnt+1.
  - Else (cnt==DEBOUNCE_CYCLES-1, cnt holds): target<=candidate.
- Debounce latency: a clean SW change is loaded into target on rising edge SYNC_STAGES+DEBOUNCE_CYCLES+1 after the change. Any bounce restarts the count.
- Step timer: free-running 0..STEP_CYCLES-1, wraps to 0.
  - tick=1 in the cycle where timer==STEP_CYCLES-1.
  - First tick is at edge STEP_CYCLES after reset release.
  - Not affected by HOLD or target changes.
- FSM states are IDLE, RAMP_UP, RAMP_DOWN. Next state is computed every cycle from the next-cycle values of target and DUTY:
  - target > DUTY: RAMP_UP.
  - target < DUTY: RAMP_DOWN.
  - equal: IDLE.
  - A target change mid-ramp may reverse direction; it takes effect from the next tick with no restart of the timer.
- On a tick with HOLD=0:
  - RAMP_UP: DUTY<=min(DUTY+STEP, target).
  - RAMP_DOWN: DUTY<=max(DUTY-STEP, target).
  - Arithmetic is done in WIDTH+1 bits, so there is no wrap past 2^WIDTH-1 or below 0 and no overshoot of target.
- IDLE or HOLD=1: DUTY unchanged.
- AT_TARGET: registered as (next state == IDLE).
- UPDATE: registered as (DUTY_next != DUTY).
- Simultaneous tick and target load on the same edge: the DUTY step uses the old target; the new target governs from the following cycle.
- Target equal to current DUTY: no UPDATE pulse; AT_TARGET stays 1.

Test Plan (bench overrides: DEBOUNCE_CYCLES=4, STEP_CYCLES=4, STEP=1 unless noted):
- Reset: assert RST_N=0 asynchronously mid-cycle during a ramp (DUTY=5) -> DUTY=0, AT_TARGET=1, UPDATE=0 without waiting for CLK; hold SW=0 after release -> no UPDATE ever.
- Debounce latency: SW 0->3 cleanly one cycle after reset release -> target=3 exactly 7 edges later; AT_TARGET falls the cycle after; DUTY steps 0->1->2->3 on ticks 4 clocks apart, one UPDATE pulse per step; AT_TARGET=1 after DUTY=3.
- Bounce rejection: SW toggles 0x10/0x00 every 2 cycles for 20 cycles, then settles at 0x00 -> target never leaves 0, DUTY stays 0, no UPDATE.
- Reversal mid-ramp: target 10 accepted; at DUTY=4, SW->2 -> after debounce, DUTY decreases 4(or current)->3->2 and stops; no overshoot below 2.
- Saturation, STEP=100: SW=0xFF -> DUTY 0->100->200->255, then AT_TARGET=1; SW=0x00 -> 255->155->55->0, no wrap.
- HOLD: during ramp to 8, HOLD=1 for 12 cycles at DUTY=3 -> DUTY stays 3, no UPDATE; HOLD=0 -> ramp resumes at the next tick, timer phase unchanged.

Source files
------------

// File: rtl/duty_ramp_ctrl.sv
// ============================================================================
// Module  : duty_ramp_ctrl
// Brief   : Synchronises and debounces a switch bank into a target duty value,
//           then slews DUTY toward it by STEP once per PWM frame.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module duty_ramp_ctrl #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int STEP_CYCLES     = 257,
    parameter int STEP            = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] SW,
    input  logic             HOLD,
    output logic [WIDTH-1:0] DUTY,
    output logic             AT_TARGET,
    output logic             UPDATE
);

    localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int               TMR_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(STEP_CYCLES - 1);
    localparam logic [WIDTH:0]   STEP_EXT = (WIDTH + 1)'(STEP);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } state_t;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] sync_sw;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    state_t           state_q, state_d;
    logic             at_target_q, at_target_d;
    logic             update_q, update_d;
    logic             tick;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    assign sync_sw = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = SW;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Any disagreement with the candidate restarts the stability count.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        if (sync_sw != cand_q) begin
            cand_d = sync_sw;
            cnt_d  = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            target_d = cand_q;
        end
    end

    always_comb begin
        tick    = (timer_q == TMR_MAX);
        timer_d = tick ? '0 : timer_q + TMR_W'(1);
    end

    // The step uses the registered target, so a target loaded on a tick edge
    // only governs from the following cycle.
    always_comb begin
        sum    = {1'b0, duty_q} + STEP_EXT;
        diff   = {1'b0, duty_q} - STEP_EXT;
        duty_d = duty_q;
        if (tick && !HOLD) begin
            case (state_q)
                RAMP_UP:   duty_d = (sum > {1'b0, target_q}) ? target_q : sum[WIDTH-1:0];
                RAMP_DOWN: duty_d = (diff[WIDTH] || (diff[WIDTH-1:0] < target_q)) ?
                                    target_q : diff[WIDTH-1:0];
                default:   duty_d = duty_q;
            endcase
        end

        if (target_d > duty_d) begin
            state_d = RAMP_UP;
        end else if (target_d < duty_d) begin
            state_d = RAMP_DOWN;
        end else begin
            state_d = IDLE;
        end

        at_target_d = (state_d == IDLE);
        update_d    = (duty_d != duty_q);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            cand_q      <= '0;
            cnt_q       <= '0;
            target_q    <= '0;
            timer_q     <= '0;
            duty_q      <= '0;
            state_q     <= IDLE;
            at_target_q <= 1'b1;
            update_q    <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            target_q    <= target_d;
            timer_q     <= timer_d;
            duty_q      <= duty_d;
            state_q     <= state_d;
            at_target_q <= at_target_d;
            update_q    <= update_d;
        end
    end

    assign DUTY      = duty_q;
    assign AT_TARGET = at_target_q;
    assign UPDATE    = update_q;

endmodule

`default_nettype wire

// File: tb/tb_duty_ramp_ctrl.sv
// ============================================================================
// Module  : tb_duty_ramp_ctrl
// Brief   : Directed vector table plus hand-written sequences for duty_ramp_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_duty_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, hold;
    logic [7:0] sw;
    logic [7:0] duty;
    logic       at_tgt, upd;
    logic       rst_n2, hold2;
    logic [7:0] sw2;
    logic [7:0] duty2;
    logic       at_tgt2, upd2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    duty_ramp_ctrl #(
        .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .STEP_CYCLES(4), .STEP(1)
    ) u_dut (
        .CLK(clk), .RST_N(rst_n), .SW(sw), .HOLD(hold),
        .DUTY(duty), .AT_TARGET(at_tgt), .UPDATE(upd)
    );

    duty_ramp_ctrl #(
        .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .STEP_CYCLES(4), .STEP(100)
    ) u_dut_sat (
        .CLK(clk), .RST_N(rst_n2), .SW(sw2), .HOLD(hold2),
        .DUTY(duty2), .AT_TARGET(at_tgt2), .UPDATE(upd2)
    );

    typedef struct {
        bit         rst;
        logic [7:0] sw;
        bit         hold;
        int         n;
        int         exp_duty;
        bit         exp_at;
        int         exp_upd;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit rst, input int swv, input bit hd, input int n,
                                input int d, input bit a, input int u);
        vec_t v;
        v.rst = rst; v.sw = 8'(swv); v.hold = hd; v.n = n;
        v.exp_duty = d; v.exp_at = a; v.exp_upd = u;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called just after a rising edge; the next rising edge is edge 1 after release.
    task automatic reset1();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run1(input int n, output int u);
        u = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (upd) u++;
        end
    endtask

    task automatic run2(input int n, output int u);
        u = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (upd2) u++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int u;
        rst_n = 1'b0; rst_n2 = 1'b0;
        sw = 8'h00; sw2 = 8'h00; hold = 1'b0; hold2 = 1'b0;

        // Bounce rejection: toggling every 2 cycles never survives 4 stable cycles.
        for (int i = 0; i < 10; i++) begin
            add(i == 0, (i % 2 == 0) ? 8'h10 : 8'h00, 0, 2, 0, 1, 0);
        end
        add(0, 8'h00, 0, 10, 0, 1, 0);

        // Debounce latency: change before edge 2, target loads on edge 8.
        add(1, 0, 0, 1, 0, 1, 0);
        add(0, 3, 0, 6, 0, 1, 0);
        add(0, 3, 0, 1, 0, 0, 0);
        add(0, 3, 0, 4, 1, 0, 1);
        add(0, 3, 0, 4, 2, 0, 1);
        add(0, 3, 0, 4, 3, 1, 1);
        add(0, 3, 0, 8, 3, 1, 0);

        // Reversal: target 10 at edge 7, DUTY 4 at edge 20, SW->2 loads at edge 27.
        add(1, 10, 0, 6, 0, 1, 0);
        add(0, 10, 0, 1, 0, 0, 0);
        add(0, 10, 0, 13, 4, 0, 4);
        add(0, 2, 0, 4, 5, 0, 1);
        add(0, 2, 0, 4, 4, 0, 1);
        add(0, 2, 0, 8, 2, 1, 2);
        add(0, 2, 0, 8, 2, 1, 0);

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            sw   = vecs[i].sw;
            hold = vecs[i].hold;
            if (vecs[i].rst) reset1();
            run1(vecs[i].n, u);
            check($sformatf("vec%0d duty", i), int'(duty), vecs[i].exp_duty);
            check($sformatf("vec%0d at_target", i), int'(at_tgt), int'(vecs[i].exp_at));
            check($sformatf("vec%0d update_count", i), u, vecs[i].exp_upd);
        end

        // HOLD freezes DUTY at 3 across three ticks; timer phase is preserved.
        sw = 8'd8; hold = 1'b0;
        reset1();
        run1(16, u);
        check("hold pre duty", int'(duty), 3);
        check("hold pre updates", u, 3);
        hold = 1'b1;
        run1(12, u);
        check("hold frozen duty", int'(duty), 3);
        check("hold frozen updates", u, 0);
        hold = 1'b0;
        run1(3, u);
        check("hold release pre-tick duty", int'(duty), 3);
        check("hold release pre-tick updates", u, 0);
        run1(1, u);
        check("hold resume duty", int'(duty), 4);
        check("hold resume update", int'(upd), 1);
        run1(16, u);
        check("hold final duty", int'(duty), 8);
        check("hold final at_target", int'(at_tgt), 1);
        check("hold final updates", u, 4);

        // Asynchronous reset mid-ramp, right after a step edge.
        sw = 8'd8;
        reset1();
        run1(24, u);
        check("async pre duty", int'(duty), 5);
        check("async pre update", int'(upd), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async duty", int'(duty), 0);
        check("async at_target", int'(at_tgt), 1);
        check("async update", int'(upd), 0);
        sw = 8'd0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        run1(20, u);
        check("post reset duty", int'(duty), 0);
        check("post reset at_target", int'(at_tgt), 1);
        check("post reset updates", u, 0);

        // Saturation with STEP=100: clamps at 255 going up and 0 going down.
        sw2 = 8'hFF;
        rst_n2 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n2 = 1'b1;
        run2(8, u);
        check("sat up1 duty", int'(duty2), 100);
        run2(4, u);
        check("sat up2 duty", int'(duty2), 200);
        run2(4, u);
        check("sat up3 duty", int'(duty2), 255);
        check("sat up3 at_target", int'(at_tgt2), 1);
        sw2 = 8'h00;
        run2(8, u);
        check("sat dn1 duty", int'(duty2), 155);
        check("sat dn1 at_target", int'(at_tgt2), 0);
        check("sat dn1 updates", u, 1);
        run2(4, u);
        check("sat dn2 duty", int'(duty2), 55);
        run2(4, u);
        check("sat dn3 duty", int'(duty2), 0);
        check("sat dn3 at_target", int'(at_tgt2), 1);
        run2(8, u);
        check("sat idle duty", int'(duty2), 0);
        check("sat idle updates", u, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
